// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage vector core (IF, ID, EX, MEM, WB).
// Holds the decoder BR encodings, the major opcodes, the default register
// address width, and the control encoding for the hazard scoreboard.
package core_pkg;

  localparam int REG_AW = 5;

  // Decoder BR field: bit 1 marks a conditional branch resolved in ID.
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_VBNZ = 2'b10,
    BR_VBEZ = 2'b11
  } br_t;

  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_LD    = 6'b100000;
  localparam logic [5:0] OP_SD    = 6'b100001;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  // Scoreboard update for one edge: freeze, shift in an empty slot, or
  // shift in the writer now leaving ID.
  typedef enum logic [1:0] {
    SB_HOLD   = 2'b00,
    SB_BUBBLE = 2'b01,
    SB_LOAD   = 2'b10
  } sb_op_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry record of in-flight register writes (EX, MEM, WB) and the
// comparison of those writes against the source operands sitting in ID.
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   op                HOLD / BUBBLE / LOAD for this edge
//   ins_v, ins_rd     writer entering EX (used only on LOAD)
//   id_valid          ID holds a real instruction
//   id_ra, id_use_a   source A and whether it is a true operand
//   id_rb, id_use_b   source B and whether it is a true operand
//   hit               some true operand matches a tracked write
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int REG_AW = core_pkg::REG_AW,
  parameter bit CHK_WB = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  sb_op_t            op,
  input  logic              ins_v,
  input  logic [REG_AW-1:0] ins_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic              id_use_a,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_b,
  output logic              hit
);

  // Entry 0 = EX, 1 = MEM, 2 = WB.  The WB entry only matters when the
  // register file cannot write before read in the same cycle.
  localparam int DEPTH = CHK_WB ? 3 : 2;

  logic [2:0]        v_q;
  logic [REG_AW-1:0] rd_q [3];

  // NOTE: state registers use non-blocking assignments so every flop in the
  // block samples the pre-edge value of its neighbour during the shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      case (op)
        SB_LOAD:   v_q <= {v_q[1], v_q[0], ins_v};
        SB_BUBBLE: v_q <= {v_q[1], v_q[0], 1'b0};
        default:   v_q <= v_q;
      endcase
    end
  end

  // NOTE: the address fields carry no reset; an entry is meaningless until
  // its valid bit is set, and valid bits are always cleared by reset.
  always_ff @(posedge clk) begin
    if (op != SB_HOLD) begin
      rd_q[2] <= rd_q[1];
      rd_q[1] <= rd_q[0];
      rd_q[0] <= ins_rd;
    end
  end

  // R0 is an ordinary register here, so there is no zero-address exemption.
  logic hit_a;
  logic hit_b;

  // NOTE: every variable written in a combinational block gets a default
  // first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < DEPTH && v_q[i]) begin
        if (rd_q[i] == id_ra) hit_a = 1'b1;
        if (rd_q[i] == id_rb) hit_b = 1'b1;
      end
    end
    hit = id_valid & ((hit_a & id_use_a) | (hit_b & id_use_b));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage vector core.  Detects read-after-write
// hazards against in-flight writes (no forwarding), stalls PC and IF/ID,
// inserts ID/EX bubbles, flushes IF/ID on a taken VBNZ/VBEZ, obeys a global
// freeze from the memory/NIC side and counts stall cycles.
// Priority: ext_stall > data hazard > branch flush.
// Ports:
//   clk, reset                       core clock, synchronous active-high reset
//   id_valid, id_ra, id_rb           ID instruction and its source addresses
//   id_use_a, id_use_b               which sources are true operands
//   id_rd, id_wr_en                  destination and write enable
//   id_br, br_taken                  branch type and ID comparator result
//   ext_stall                        freeze the whole pipeline
//   pc_we, ifid_we                   PC and IF/ID enables
//   ifid_flush, idex_bubble          NOP injection into IF/ID and ID/EX
//   haz_stall                        data-hazard stall this cycle
//   stall_cnt                        wrapping count of stalled cycles
module hazard_ctrl #(
  parameter int REG_AW = core_pkg::REG_AW,
  parameter bit CHK_WB = 1'b0,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic [1:0]        id_br,
  input  logic              br_taken,
  input  logic              ext_stall,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              haz_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  import core_pkg::*;

  logic   raw_hit;
  logic   is_cond_br;
  sb_op_t sb_op;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .CHK_WB (CHK_WB)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .op       (sb_op),
    .ins_v    (id_valid & id_wr_en),
    .ins_rd   (id_rd),
    .id_valid (id_valid),
    .id_ra    (id_ra),
    .id_use_a (id_use_a),
    .id_rb    (id_rb),
    .id_use_b (id_use_b),
    .hit      (raw_hit)
  );

  assign is_cond_br = (id_br == BR_VBNZ) || (id_br == BR_VBEZ);

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    haz_stall   = 1'b0;
    sb_op       = SB_LOAD;
    if (ext_stall) begin
      // Whole pipeline frozen: a pending branch is simply re-evaluated later.
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      sb_op   = SB_HOLD;
    end else if (raw_hit) begin
      // Operand not ready: hold IF/ID, send a bubble down, and ignore any
      // branch outcome computed from the stale operand.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      haz_stall   = 1'b1;
      sb_op       = SB_BUBBLE;
    end else begin
      ifid_flush = id_valid & is_cond_br & br_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (ext_stall | haz_stall) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage vector core: IF, ID, EX, MEM, WB.
- Keeps a scoreboard of in-flight register writes and compares it against the source registers of the instruction now in ID.
- Drives the PC / IF-ID write enables, ID/EX bubble insertion and IF-ID flush on taken VBNZ/VBEZ.
- Honours a global freeze from the memory/NIC side and keeps a stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width.
- CHK_WB, 0, 1 = also check the WB-stage entry (register file without write-before-read); 0 = WB entry ignored.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 = NOP/bubble)
- id_ra  in  REG_AW  HDU_A source address from the decoder
- id_rb  in  REG_AW  HDU_B source address from the decoder
- id_use_a  in  1  id_ra is a true operand (R-type, VBNZ/VBEZ, SD)
- id_use_b  in  1  id_rb is a true operand (R-type only)
- id_rd  in  REG_AW  destination (arithmatic_RD)
- id_wr_en  in  1  decoder writen_en
- id_br  in  2  decoder BR (10 VBNZ, 11 VBEZ, others none)
- br_taken  in  1  ID-stage branch comparator result, valid when id_br[1]=1
- ext_stall  in  1  memory/NIC not ready; freeze the whole pipeline
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID register enable
- ifid_flush  out  1  load NOP into IF/ID on the next edge
- idex_bubble  out  1  load NOP into ID/EX on the next edge
- haz_stall  out  1  data-hazard stall this cycle
- stall_cnt  out  CNT_W  cycles with haz_stall=1 or ext_stall=1

Behaviour:
- Scoreboard: three entries {v, rd} for EX, MEM, WB. Registered; all cleared on reset.
- R0 is an ordinary register; no zero-register exemption.
- Match rule, combinational:
  - A hit on id_ra occurs when id_valid & id_use_a & an entry has v=1 and rd=id_ra, checking EX, MEM, and WB only if CHK_WB=1.
  - The same rule applies to id_rb with id_use_b.
  - haz_stall = hitA | hitB.
- Priority: ext_stall > haz_stall > branch flush.
- ext_stall=1:
  - pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=0, haz_stall forced to 0.
  - Scoreboard holds.
- haz_stall=1, ext_stall=0:
  - pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0.
  - Scoreboard shifts: WB<-MEM, MEM<-EX, EX<-{0,x}.
  - A branch in ID with a hazard is not resolved this cycle; its br_taken is ignored.
- No stall:
  - pc_we=1, ifid_we=1, idex_bubble=0.
  - Scoreboard shifts with EX<-{id_valid&id_wr_en, id_rd}.
  - ifid_flush = id_valid & id_br[1] & br_taken. One cycle only; the fetched wrong-path instruction becomes a NOP.
- A load (LD) is tracked as a normal writer; there is no forwarding, so dependents wait until the writer leaves MEM (or WB if CHK_WB=1).
- Worst-case hazard latency with CHK_WB=0: a dependent directly behind a writer stalls 2 cycles; with CHK_WB=1 it stalls 3 cycles.
- stall_cnt:
  - Increments by 1 on each edge where ext_stall|haz_stall.
  - Wraps to 0 from all-ones.
  - Resets to 0.
- Reset while stalled or flushing: on the next edge all scoreboard entries are invalid and stall_cnt=0.
- Outputs are combinational from scoreboard + ID inputs, so with the scoreboard cleared the post-reset values are pc_we=1, ifid_we=1, flush=0, bubble=0, haz_stall=0.
- A branch with no register conflict, taken with ext_stall=1, is held (no flush) and re-evaluated the next cycle.

Decomposition:
- Shared package (core_pkg): BR encodings (BR_NONE=00, BR_VBNZ=10, BR_VBEZ=11), opcode constants (R-type 101010, LD 100000, SD 100001, NOP 111100), REG_AW.
- One sub-module, hazard_scoreboard: the 3-entry shift register with hold/bubble/load control and the match compare.
- The top level owns priority logic, the flush and the counter.

Test Plan:
- Reset held 2 cycles with random inputs -> scoreboard empty, stall_cnt=0, pc_we=1, haz_stall=0.
- R-type writing R5, then R-type reading R5 as rA, CHK_WB=0 -> haz_stall=1 for 2 cycles, idex_bubble=1 both cycles, issue on cycle 3, stall_cnt=2.
- Same sequence with CHK_WB=1 -> 3 stall cycles, stall_cnt=3; a dependent separated by 3 independent instructions -> 0 stalls.
- VBNZ on R2 with no conflict and br_taken=1 -> ifid_flush=1 exactly one cycle, pc_we=1.
- VBEZ on R2 one instruction behind an LD to R2 -> stalls first with flush=0, then flush=1 once resolved.
- ext_stall=1 for 4 cycles during a pending hazard -> scoreboard frozen, haz_stall=0, stall_cnt+4, then the hazard resumes with its remaining count unchanged.
- Writer with id_wr_en=0 (SD, R3) followed by a reader of R3 -> no stall.
